// File: rtl/sqrt_pkg.sv
// Width helpers shared by the pipelined integer square-root unit.
// Result width is half the radical width, rounded up.
package sqrt_pkg;

    function automatic int q_width(input int dw);
        return (dw + 1) / 2;
    endfunction

    function automatic int r_width(input int dw);
        return q_width(dw) + 1;
    endfunction

endpackage

// File: rtl/sqrt_stage.sv
// One restoring square-root digit step: consumes two radical bits and
// produces one more quotient bit plus the updated partial remainder.
module sqrt_stage #(
    parameter int Q_WIDTH = 11,
    parameter int R_WIDTH = Q_WIDTH + 1
) (
    input  logic [1:0]         rad_bits,
    input  logic [Q_WIDTH-1:0] q_in,
    input  logic [R_WIDTH-1:0] rem_in,
    output logic [Q_WIDTH-1:0] q_out,
    output logic [R_WIDTH-1:0] rem_out
);

    // One spare bit above the shifted remainder so the MSB of the difference is a clean borrow.
    localparam int W = R_WIDTH + 3;

    logic [W-1:0] r_sh;
    logic [W-1:0] trial;
    logic [W-1:0] diff;
    logic         neg;

    always_comb begin
        r_sh    = W'({rem_in, rad_bits});
        trial   = W'({q_in, 2'b01});
        diff    = r_sh - trial;
        neg     = diff[W-1];
        q_out   = Q_WIDTH'({q_in, ~neg});
        rem_out = neg ? R_WIDTH'(r_sh) : R_WIDTH'(diff);
    end

endmodule

// File: rtl/sqrt_pipe.sv
// Fully pipelined floor(sqrt) with remainder and tag sideband; one stage
// per result bit, whole pipeline freezes while the consumer stalls.
module sqrt_pipe
    import sqrt_pkg::*;
#(
    parameter int  DATA_WIDTH = 21,
    parameter int  TAG_WIDTH  = 32,
    localparam int Q_WIDTH    = q_width(DATA_WIDTH),
    localparam int R_WIDTH    = r_width(DATA_WIDTH)
) (
    input  logic                  clk_main,
    input  logic                  sys_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] radical,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Q_WIDTH-1:0]    q,
    output logic [R_WIDTH-1:0]    remainder,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    localparam int RAD_WIDTH = 2 * Q_WIDTH;

    typedef struct packed {
        logic                 valid;
        logic [Q_WIDTH-1:0]   q;
        logic [R_WIDTH-1:0]   rem;
        logic [RAD_WIDTH-1:0] rad_rest;
        logic [TAG_WIDTH-1:0] tag;
    } stage_t;

    stage_t               pipe    [Q_WIDTH];
    logic [RAD_WIDTH-1:0] rad_src [Q_WIDTH];
    logic [Q_WIDTH-1:0]   q_src   [Q_WIDTH];
    logic [Q_WIDTH-1:0]   q_nxt   [Q_WIDTH];
    logic [R_WIDTH-1:0]   rem_src [Q_WIDTH];
    logic [R_WIDTH-1:0]   rem_nxt [Q_WIDTH];
    logic                 stall;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < Q_WIDTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign rad_src[k] = RAD_WIDTH'(radical);
            assign q_src[k]   = '0;
            assign rem_src[k] = '0;
        end else begin : g_body
            assign rad_src[k] = pipe[k-1].rad_rest;
            assign q_src[k]   = pipe[k-1].q;
            assign rem_src[k] = pipe[k-1].rem;
        end

        sqrt_stage #(
            .Q_WIDTH (Q_WIDTH),
            .R_WIDTH (R_WIDTH)
        ) u_stage (
            .rad_bits (rad_src[k][RAD_WIDTH-1 -: 2]),
            .q_in     (q_src[k]),
            .rem_in   (rem_src[k]),
            .q_out    (q_nxt[k]),
            .rem_out  (rem_nxt[k])
        );
    end

    // Bubbles shift like data; nothing moves while the output is stalled.
    always_ff @(posedge clk_main or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < Q_WIDTH; k++) begin
                pipe[k] <= '0;
            end
        end else if (!stall) begin
            pipe[0].valid    <= in_valid;
            pipe[0].q        <= q_nxt[0];
            pipe[0].rem      <= rem_nxt[0];
            pipe[0].rad_rest <= rad_src[0] << 2;
            pipe[0].tag      <= in_tag;
            for (int k = 1; k < Q_WIDTH; k++) begin
                pipe[k].valid    <= pipe[k-1].valid;
                pipe[k].q        <= q_nxt[k];
                pipe[k].rem      <= rem_nxt[k];
                pipe[k].rad_rest <= pipe[k-1].rad_rest << 2;
                pipe[k].tag      <= pipe[k-1].tag;
            end
        end
    end

    assign out_valid = pipe[Q_WIDTH-1].valid;
    assign q         = pipe[Q_WIDTH-1].q;
    assign remainder = pipe[Q_WIDTH-1].rem;
    assign out_tag   = pipe[Q_WIDTH-1].tag;

endmodule

// File: tb/tb_sqrt_pipe.sv
// Directed bench for sqrt_pipe: corners, streaming, backpressure, fill,
// mid-stream reset, and 8/32-bit variants against a bitwise reference.
module tb_sqrt_pipe;

    localparam int DW = 21;
    localparam int TW = 32;
    localparam int QW = 11;
    localparam int RW = 12;

    logic          clk_main  = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [DW-1:0] radical   = '0;
    logic [TW-1:0] in_tag    = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [QW-1:0] q;
    logic [RW-1:0] remainder;
    logic [TW-1:0] out_tag;

    logic          in_valid8 = 1'b0;
    logic          in_ready8;
    logic [7:0]    radical8  = '0;
    logic [7:0]    in_tag8   = '0;
    logic          out_valid8;
    logic          out_ready8 = 1'b1;
    logic [3:0]    q8;
    logic [4:0]    rem8;
    logic [7:0]    out_tag8;

    logic          in_valid32 = 1'b0;
    logic          in_ready32;
    logic [31:0]   radical32  = '0;
    logic [15:0]   in_tag32   = '0;
    logic          out_valid32;
    logic          out_ready32 = 1'b1;
    logic [15:0]   q32;
    logic [16:0]   rem32;
    logic [15:0]   out_tag32;

    int checks = 0;
    int errors = 0;

    always #5 clk_main = ~clk_main;

    sqrt_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk_main (clk_main), .sys_rst_n (sys_rst_n),
        .in_valid (in_valid), .in_ready (in_ready), .radical (radical), .in_tag (in_tag),
        .out_valid (out_valid), .out_ready (out_ready), .q (q), .remainder (remainder),
        .out_tag (out_tag)
    );

    sqrt_pipe #(.DATA_WIDTH(8), .TAG_WIDTH(8)) dut8 (
        .clk_main (clk_main), .sys_rst_n (sys_rst_n),
        .in_valid (in_valid8), .in_ready (in_ready8), .radical (radical8), .in_tag (in_tag8),
        .out_valid (out_valid8), .out_ready (out_ready8), .q (q8), .remainder (rem8),
        .out_tag (out_tag8)
    );

    sqrt_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(16)) dut32 (
        .clk_main (clk_main), .sys_rst_n (sys_rst_n),
        .in_valid (in_valid32), .in_ready (in_ready32), .radical (radical32), .in_tag (in_tag32),
        .out_valid (out_valid32), .out_ready (out_ready32), .q (q32), .remainder (rem32),
        .out_tag (out_tag32)
    );

    // Bit-by-bit greedy root: largest r with r*r <= x.
    function automatic longint isqrt(input longint x);
        longint r;
        longint c;
        r = 0;
        for (int b = 16; b >= 0; b--) begin
            c = r | (longint'(1) << b);
            if (c * c <= x) r = c;
        end
        return r;
    endfunction

    task automatic run_single(input logic [DW-1:0] rad, input logic [TW-1:0] tag,
                              output int lat, output logic [QW-1:0] oq,
                              output logic [RW-1:0] orem, output logic [TW-1:0] otag,
                              output logic still_valid);
        @(negedge clk_main);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        radical   = rad;
        in_tag    = tag;
        @(posedge clk_main);
        @(negedge clk_main);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk_main);
            lat++;
        end
        oq   = q;
        orem = remainder;
        otag = out_tag;
        @(negedge clk_main);
        still_valid = out_valid;
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge clk_main);
        checks++;
        if (out_valid !== 1'b0 || q !== '0 || remainder !== '0 || out_tag !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b q=%0d r=%0d tag=%0h, required all 0",
                     out_valid, q, remainder, out_tag);
        end
        checks++;
        if (out_valid8 !== 1'b0 || out_valid32 !== 1'b0) begin
            errors++;
            $display("FAIL reset_variants: valid8=%0b valid32=%0b, required 0", out_valid8, out_valid32);
        end
        sys_rst_n = 1'b1;
        @(negedge clk_main);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        end
    endtask

    task automatic test_corners;
        logic [DW-1:0] rads [4];
        logic [QW-1:0] eq   [4];
        logic [RW-1:0] er   [4];
        int            lat;
        logic [QW-1:0] oq;
        logic [RW-1:0] orem;
        logic [TW-1:0] otag;
        logic          sv;
        rads = '{21'd0, 21'd3, 21'd1048576, 21'd2097151};
        eq   = '{11'd0, 11'd1, 11'd1024, 11'd1448};
        er   = '{12'd0, 12'd2, 12'd0, 12'd447};
        for (int i = 0; i < 4; i++) begin
            run_single(rads[i], 32'hC0DE_0000 + i, lat, oq, orem, otag, sv);
            checks++;
            if (lat !== QW) begin
                errors++;
                $display("FAIL corner_latency[%0d]: got %0d, required %0d", i, lat, QW);
            end
            checks++;
            if (oq !== eq[i] || orem !== er[i]) begin
                errors++;
                $display("FAIL corner_result[%0d]: got q=%0d r=%0d, required q=%0d r=%0d",
                         i, oq, orem, eq[i], er[i]);
            end
            checks++;
            if (otag !== 32'hC0DE_0000 + i) begin
                errors++;
                $display("FAIL corner_tag[%0d]: got %0h, required %0h", i, otag, 32'hC0DE_0000 + i);
            end
            checks++;
            if (sv !== 1'b0) begin
                errors++;
                $display("FAIL corner_single_emit[%0d]: out_valid %0b after consume, required 0", i, sv);
            end
        end
    endtask

    task automatic test_stream;
        int sent, rcvd, cyc, first_out, last_out;
        logic [QW-1:0] exp_q;
        logic [RW-1:0] exp_r;
        sent = 0; rcvd = 0; cyc = 0; first_out = -1; last_out = -1;
        out_ready = 1'b1;
        while (rcvd < 501 && cyc < 2000) begin
            @(negedge clk_main);
            in_valid = (sent < 501);
            radical  = DW'(sent * sent + 3);
            in_tag   = TW'(sent);
            #1;
            if (out_valid) begin
                exp_q = (rcvd == 0) ? 11'd1 : (rcvd == 1) ? 11'd2 : QW'(rcvd);
                exp_r = (rcvd == 0) ? 12'd2 : (rcvd == 1) ? 12'd0 : 12'd3;
                checks++;
                if (q !== exp_q || remainder !== exp_r || out_tag !== TW'(rcvd)) begin
                    errors++;
                    $display("FAIL stream[%0d]: got q=%0d r=%0d tag=%0d, required q=%0d r=%0d tag=%0d",
                             rcvd, q, remainder, out_tag, exp_q, exp_r, rcvd);
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (rcvd !== 501) begin
            errors++;
            $display("FAIL stream_count: got %0d results, required 501", rcvd);
        end
        checks++;
        if (first_out !== QW || last_out - first_out !== 500) begin
            errors++;
            $display("FAIL stream_timing: first=%0d span=%0d, required first=%0d span=500",
                     first_out, last_out - first_out, QW);
        end
    endtask

    task automatic test_backpressure;
        logic [DW-1:0] rads [40];
        logic [QW-1:0] prev_q;
        logic [RW-1:0] prev_r;
        logic [TW-1:0] prev_tag;
        logic          prev_stall;
        longint        eq;
        int            sent, rcvd, cyc;
        for (int i = 0; i < 40; i++) rads[i] = DW'($urandom_range(0, (1 << DW) - 1));
        sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0;
        prev_q = '0; prev_r = '0; prev_tag = '0;
        while (rcvd < 40 && cyc < 2000) begin
            @(negedge clk_main);
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 40);
            radical   = rads[(sent < 40) ? sent : 0];
            in_tag    = 32'hB000_0000 + TW'(sent);
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL bp_in_ready: got %0b with out_valid=%0b out_ready=%0b", in_ready, out_valid, out_ready);
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || q !== prev_q || remainder !== prev_r || out_tag !== prev_tag) begin
                    errors++;
                    $display("FAIL bp_hold: got v=%0b q=%0d r=%0d tag=%0h, required v=1 q=%0d r=%0d tag=%0h",
                             out_valid, q, remainder, out_tag, prev_q, prev_r, prev_tag);
                end
            end
            if (out_valid && out_ready) begin
                eq = isqrt(longint'(rads[rcvd]));
                checks++;
                if (q !== QW'(eq) || remainder !== RW'(longint'(rads[rcvd]) - eq * eq) ||
                    out_tag !== 32'hB000_0000 + TW'(rcvd)) begin
                    errors++;
                    $display("FAIL bp_result[%0d]: got q=%0d r=%0d tag=%0h, required q=%0d r=%0d tag=%0h",
                             rcvd, q, remainder, out_tag, eq, longint'(rads[rcvd]) - eq * eq,
                             32'hB000_0000 + rcvd);
                end
                rcvd++;
            end
            prev_stall = out_valid && !out_ready;
            prev_q     = q;
            prev_r     = remainder;
            prev_tag   = out_tag;
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcvd !== 40) begin
            errors++;
            $display("FAIL bp_count: got %0d results, required 40", rcvd);
        end
        repeat (QW + 2) @(negedge clk_main);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_duplicate: out_valid %0b after drain, required 0", out_valid);
        end
    endtask

    task automatic test_fill_stalled;
        int sent, rcvd, cyc;
        int n;
        sent = 0; rcvd = 0; cyc = 0;
        out_ready = 1'b0;
        repeat (25) begin
            @(negedge clk_main);
            in_valid = (sent < 20);
            n        = 100 + sent;
            radical  = DW'(n * n + n);
            in_tag   = TW'(n);
            #1;
            if (in_valid && in_ready) sent++;
        end
        checks++;
        if (sent !== QW) begin
            errors++;
            $display("FAIL fill_accepted: got %0d accepted, required %0d", sent, QW);
        end
        while (rcvd < 20 && cyc < 200) begin
            @(negedge clk_main);
            out_ready = 1'b1;
            in_valid  = (sent < 20);
            n         = 100 + sent;
            radical   = DW'(n * n + n);
            in_tag    = TW'(n);
            #1;
            if (out_valid) begin
                checks++;
                if (q !== QW'(100 + rcvd) || remainder !== RW'(100 + rcvd) || out_tag !== TW'(100 + rcvd)) begin
                    errors++;
                    $display("FAIL fill_result[%0d]: got q=%0d r=%0d tag=%0d, required q=r=tag=%0d",
                             rcvd, q, remainder, out_tag, 100 + rcvd);
                end
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (rcvd !== 20) begin
            errors++;
            $display("FAIL fill_count: got %0d results, required 20", rcvd);
        end
    endtask

    task automatic test_reset_mid;
        int            stale;
        int            lat;
        logic [QW-1:0] oq;
        logic [RW-1:0] orem;
        logic [TW-1:0] otag;
        logic          sv;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_main);
            in_valid = 1'b1;
            radical  = DW'(1000 + i);
            in_tag   = 32'h5000_0000 + i;
        end
        @(negedge clk_main);
        in_valid = 1'b0;
        radical  = '1;
        in_tag   = 32'hDEAD_BEEF;
        @(posedge clk_main);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || q !== '0 || remainder !== '0 || out_tag !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_outputs: v=%0b q=%0d r=%0d tag=%0h rdy=%0b, required 0/0/0/0/1",
                     out_valid, q, remainder, out_tag, in_ready);
        end
        repeat (2) @(negedge clk_main);
        sys_rst_n = 1'b1;
        stale = 0;
        repeat (20) begin
            @(negedge clk_main);
            if (out_valid) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("FAIL midreset_stale: got %0d stale outputs, required 0", stale);
        end
        run_single(21'd144, 32'h0000_0144, lat, oq, orem, otag, sv);
        checks++;
        if (lat !== QW || oq !== 11'd12 || orem !== 12'd0 || otag !== 32'h0000_0144) begin
            errors++;
            $display("FAIL midreset_after: got lat=%0d q=%0d r=%0d tag=%0h, required lat=%0d q=12 r=0 tag=144",
                     lat, oq, orem, otag, QW);
        end
    endtask

    task automatic test_width8;
        int     sent, rcvd, cyc;
        longint eq;
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 256 && cyc < 1000) begin
            @(negedge clk_main);
            in_valid8 = (sent < 256);
            radical8  = 8'(sent);
            in_tag8   = 8'(sent);
            #1;
            if (out_valid8) begin
                eq = isqrt(longint'(rcvd));
                checks++;
                if (q8 !== 4'(eq) || rem8 !== 5'(longint'(rcvd) - eq * eq) || out_tag8 !== 8'(rcvd)) begin
                    errors++;
                    $display("FAIL w8[%0d]: got q=%0d r=%0d tag=%0d, required q=%0d r=%0d tag=%0d",
                             rcvd, q8, rem8, out_tag8, eq, longint'(rcvd) - eq * eq, rcvd);
                end
                rcvd++;
            end
            if (in_valid8 && in_ready8) sent++;
            cyc++;
        end
        in_valid8 = 1'b0;
        checks++;
        if (rcvd !== 256) begin
            errors++;
            $display("FAIL w8_count: got %0d results, required 256", rcvd);
        end
    endtask

    task automatic test_width32;
        logic [31:0] rads [64];
        int          sent, rcvd, cyc;
        longint      eq;
        for (int i = 0; i < 64; i++) rads[i] = $urandom;
        rads[0] = 32'd0;
        rads[1] = 32'hFFFF_FFFF;
        rads[2] = 32'd65536;
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 64 && cyc < 500) begin
            @(negedge clk_main);
            in_valid32 = (sent < 64);
            radical32  = rads[(sent < 64) ? sent : 0];
            in_tag32   = 16'(sent);
            #1;
            if (out_valid32) begin
                eq = isqrt(longint'(rads[rcvd]));
                checks++;
                if (q32 !== 16'(eq) || rem32 !== 17'(longint'(rads[rcvd]) - eq * eq) || out_tag32 !== 16'(rcvd)) begin
                    errors++;
                    $display("FAIL w32[%0d]: got q=%0d r=%0d tag=%0d, required q=%0d r=%0d tag=%0d",
                             rcvd, q32, rem32, out_tag32, eq, longint'(rads[rcvd]) - eq * eq, rcvd);
                end
                rcvd++;
            end
            if (in_valid32 && in_ready32) sent++;
            cyc++;
        end
        in_valid32 = 1'b0;
        checks++;
        if (rcvd !== 64) begin
            errors++;
            $display("FAIL w32_count: got %0d results, required 64", rcvd);
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_stream();
        test_backpressure();
        test_fill_stalled();
        test_reset_mid();
        test_width8();
        test_width32();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
